// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cp0_pkg
// Description : Shared CP0 register numbers, exception codes, state type and
//               exception-PC helper.
// Revision    : 1.0  initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0]  C_REG_SR    = 5'd12;
    localparam logic [4:0]  C_REG_CAUSE = 5'd13;
    localparam logic [4:0]  C_REG_EPC   = 5'd14;
    localparam logic [4:0]  C_REG_EBASE = 5'd15;

    localparam logic [4:0]  C_EXC_INT     = 5'd0;
    localparam logic [4:0]  C_EXC_ADEL    = 5'd4;
    localparam logic [4:0]  C_EXC_ADES    = 5'd5;
    localparam logic [4:0]  C_EXC_SYSCALL = 5'd8;
    localparam logic [4:0]  C_EXC_RI      = 5'd10;
    localparam logic [4:0]  C_EXC_OV      = 5'd12;

    localparam logic [31:0] C_EBASE_RESET = 32'h0000_4180;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_t;

    // The handler resumes at EPC+4, so EPC points one slot before the victim.
    function automatic logic [31:0] f_epc(input logic [31:0] pc, input logic bd);
        logic [31:0] v;
        v = bd ? (pc - 32'd8) : (pc - 32'd4);
        return {v[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_req_arb.sv
`default_nettype none
// ============================================================================
// Module      : cp0_req_arb
// Description : Interrupt/exception request arbitration and ExcCode select.
// Revision    : 1.0  initial release
// ============================================================================
module cp0_req_arb
    import cp0_pkg::*;
(
    input  logic       i_exl,
    input  logic       i_ie,
    input  logic [5:0] i_im,
    input  logic [5:0] i_hw_int,
    input  logic [4:0] i_exc_code,
    output logic       o_req,
    output logic [4:0] o_exc_code
);

    logic w_int_pend;

    assign w_int_pend = i_ie & (|(i_hw_int & i_im));
    assign o_req      = ~i_exl & (w_int_pend | (i_exc_code != 5'd0));
    assign o_exc_code = w_int_pend ? C_EXC_INT : i_exc_code;

endmodule
`default_nettype wire

// File: rtl/cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_ctrl
// Description : CP0 register file (SR, Cause, EPC, EBase) with exception entry
//               and eret handling. Macro CP0_EBASE_WR_EN makes EBase writable.
// Revision    : 1.0  initial release
// ============================================================================
module cp0_ctrl
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        M_eret,
    output logic        Req,
    output logic [31:0] EPC_out,
    output logic [31:0] EBase_out
);

    cp0_state_t  r_state;
    cp0_state_t  w_state_next;
    logic [5:0]  r_im;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic        w_exl;
    logic        w_req_raw;
    logic [4:0]  w_exc_sel;
    logic        w_sr_wr;

    assign w_exl   = (r_state == ST_HANDLER);
    assign w_sr_wr = we & (addr == C_REG_SR);

    cp0_req_arb u_arb (
        .i_exl      (w_exl),
        .i_ie       (r_ie),
        .i_im       (r_im),
        .i_hw_int   (hw_int),
        .i_exc_code (exc_code),
        .o_req      (w_req_raw),
        .o_exc_code (w_exc_sel)
    );

    // Req must read 0 the moment reset rises, independent of pipeline inputs.
    assign Req = w_req_raw & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (Req) begin
            w_state_next = ST_HANDLER;
        end else if (w_sr_wr) begin
            w_state_next = (M_eret || !wdata[1]) ? ST_NORMAL : ST_HANDLER;
        end else if (M_eret) begin
            w_state_next = ST_NORMAL;
        end
    end

`ifdef CP0_EBASE_WR_EN
    logic [31:0] r_ebase;
    assign EBase_out = r_ebase;
`else
    assign EBase_out = C_EBASE_RESET;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im      <= 6'd0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= 6'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
`ifdef CP0_EBASE_WR_EN
            r_ebase   <= C_EBASE_RESET;
`endif
        end else begin
            r_ip <= hw_int;
            if (Req) begin
                r_bd      <= M_BD;
                r_exccode <= w_exc_sel;
                r_epc     <= f_epc(M_PC, M_BD);
            end else if (we) begin
                case (addr)
                    C_REG_SR: begin
                        r_im <= wdata[15:10];
                        r_ie <= wdata[0];
                    end
                    C_REG_EPC: r_epc <= {wdata[31:2], 2'b00};
`ifdef CP0_EBASE_WR_EN
                    C_REG_EBASE: r_ebase <= {wdata[31:12], 12'h000};
`endif
                    default: ;
                endcase
            end
        end
    end

    assign EPC_out = r_epc;

    always_comb begin
        rdata = 32'd0;
        case (addr)
            C_REG_SR:    rdata = {16'd0, r_im, 8'd0, w_exl, r_ie};
            C_REG_CAUSE: rdata = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
            C_REG_EPC:   rdata = r_epc;
`ifdef CP0_EBASE_WR_EN
            C_REG_EBASE: rdata = r_ebase;
`endif
            default:     rdata = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_ctrl
// Description : Directed self-checking bench for cp0_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cp0_ctrl;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        M_eret;
    logic        Req;
    logic [31:0] EPC_out;
    logic [31:0] EBase_out;

    int r_checks = 0;
    int r_errors = 0;

    cp0_ctrl u_dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .M_PC      (M_PC),
        .M_BD      (M_BD),
        .exc_code  (exc_code),
        .hw_int    (hw_int),
        .M_eret    (M_eret),
        .Req       (Req),
        .EPC_out   (EPC_out),
        .EBase_out (EBase_out)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    // Step one edge, then drop the single-cycle pipeline strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        we       = 1'b0;
        M_eret   = 1'b0;
        exc_code = 5'd0;
    endtask

    logic [31:0] v_ebase_wr;
    logic [31:0] v_ebase_rd;

    initial begin
`ifdef CP0_EBASE_WR_EN
        v_ebase_wr = 32'h8000_0000;
        v_ebase_rd = 32'h8000_0000;
`else
        v_ebase_wr = 32'h0000_4180;
        v_ebase_rd = 32'h0000_0000;
`endif
        reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'd0;
        M_PC = 32'd0; M_BD = 1'b0; exc_code = 5'd8; hw_int = 6'h3F; M_eret = 1'b0;
        #1;
        check("rst_req", {31'd0, Req}, 32'd0);
        check("rst_ebase", EBase_out, 32'h0000_4180);
        rd_chk("rst_sr", 5'd12, 32'd0);
        @(posedge clk); #1;
        rd_chk("rst_cause_ip_held", 5'd13, 32'd0);
        exc_code = 5'd0; hw_int = 6'd0;
        reset = 1'b0;
        tick();
        rd_chk("post_rst_cause", 5'd13, 32'd0);

        // Interrupt path, interrupt wins over a simultaneous exception code
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
        tick();
        rd_chk("sr_wr", 5'd12, 32'h0000_0401);
        hw_int = 6'b000001; exc_code = 5'd12; M_PC = 32'h0000_1000; M_BD = 1'b0;
        #1;
        check("int_req", {31'd0, Req}, 32'd1);
        tick();
        check("int_req_exl", {31'd0, Req}, 32'd0);
        rd_chk("int_sr", 5'd12, 32'h0000_0403);
        rd_chk("int_cause", 5'd13, 32'h0000_0400);
        rd_chk("int_epc", 5'd14, 32'h0000_0FFC);
        check("int_epc_out", EPC_out, 32'h0000_0FFC);

        // Nested exception suppressed, then eret
        hw_int = 6'd0; exc_code = 5'd4;
        #1;
        check("nest_req", {31'd0, Req}, 32'd0);
        tick();
        rd_chk("nest_cause", 5'd13, 32'h0000_0000);
        rd_chk("nest_epc", 5'd14, 32'h0000_0FFC);
        M_eret = 1'b1;
        tick();
        rd_chk("eret_sr", 5'd12, 32'h0000_0401);

        // Delay-slot syscall
        exc_code = 5'd8; M_PC = 32'h0000_3010; M_BD = 1'b1;
        #1;
        check("bd_req", {31'd0, Req}, 32'd1);
        tick();
        rd_chk("bd_epc", 5'd14, 32'h0000_3008);
        rd_chk("bd_cause", 5'd13, 32'h8000_0020);
        M_eret = 1'b1;
        tick();
        rd_chk("bd_eret_sr", 5'd12, 32'h0000_0401);

        // Exception beats a same-cycle mtc0 EPC; read shows pre-edge value
        we = 1'b1; addr = 5'd14; wdata = 32'h0000_3333;
        exc_code = 5'd12; M_PC = 32'h0000_2000; M_BD = 1'b0;
        #1;
        check("ov_nobypass", rdata, 32'h0000_3008);
        check("ov_req", {31'd0, Req}, 32'd1);
        tick();
        rd_chk("ov_epc", 5'd14, 32'h0000_1FFC);
        rd_chk("ov_cause", 5'd13, 32'h0000_0030);

        // eret with mtc0 SR: IM/IE from wdata, EXL forced clear
        we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03; M_eret = 1'b1;
        tick();
        rd_chk("eret_mtc0_sr", 5'd12, 32'h0000_FC01);

        we = 1'b1; addr = 5'd14; wdata = 32'h0000_1237;
        tick();
        rd_chk("epc_wr", 5'd14, 32'h0000_1234);
        check("epc_wr_out", EPC_out, 32'h0000_1234);
        we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
        tick();
        rd_chk("cause_ro", 5'd13, 32'h0000_0030);
        M_eret = 1'b1;
        tick();
        rd_chk("eret_noexl", 5'd12, 32'h0000_FC01);

        we = 1'b1; addr = 5'd15; wdata = 32'h8000_0FFF;
        tick();
        check("ebase_out", EBase_out, v_ebase_wr);
        rd_chk("ebase_rd", 5'd15, v_ebase_rd);
        rd_chk("unmapped_rd", 5'd3, 32'd0);

        // Async reset in the middle of a handler
        exc_code = 5'd10;
        tick();
        rd_chk("ri_sr", 5'd12, 32'h0000_FC03);
        exc_code = 5'd10; hw_int = 6'h3F; addr = 5'd12;
        reset = 1'b1;
        #1;
        check("arst_sr", rdata, 32'd0);
        check("arst_req", {31'd0, Req}, 32'd0);
        check("arst_epc", EPC_out, 32'd0);
        check("arst_ebase", EBase_out, 32'h0000_4180);
        rd_chk("arst_cause", 5'd13, 32'd0);
        @(posedge clk); #1;
        rd_chk("arst_cause_hold", 5'd13, 32'd0);
        exc_code = 5'd0;
        reset = 1'b0;
        tick();
        rd_chk("rel_cause_ip", 5'd13, 32'h0000_FC00);
        check("rel_req", {31'd0, Req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 clk  input  1  system clock, all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 we  input  1  mtc0 write enable (M stage).
REQ-004 addr  input  5  CP0 register number for mtc0/mfc0.
REQ-005 wdata  input  32  mtc0 write data.
REQ-006 rdata  output  32  mfc0 read data, combinational from addr.
REQ-007 M_PC  input  32  PC of the instruction in M stage.
REQ-008 M_BD  input  1  M instruction sits in a branch delay slot.
REQ-009 exc_code  input  5  synchronous exception code from pipeline, 0 = none.
REQ-010 hw_int  input  6  external interrupt lines, level-sensitive.
REQ-011 M_eret  input  1  eret in M stage.
REQ-012 Req  output  1  exception/interrupt request to next-PC logic and pipeline flush.
REQ-013 EPC_out  output  32  current EPC register value.
REQ-014 EBase_out  output  32  handler entry address.

Function
REQ-015 Registers: SR(12) = IM[15:10], EXL[1], IE[0]; Cause(13) = BD[31], IP[15:10], ExcCode[6:2]; EPC(14); all other bits read 0.
REQ-016 State is EXL: NORMAL (EXL=0) and HANDLER (EXL=1); NORMAL->HANDLER on Req, HANDLER->NORMAL on M_eret.
REQ-017 int_pend = IE & |(hw_int & IM); Req = ~EXL & (int_pend | exc_code != 0), combinational, same cycle.
REQ-018 Interrupt has priority over exc_code: on int_pend, ExcCode latched = 0, else ExcCode latched = exc_code.
REQ-019 On Req edge: EXL<=1, BD<=M_BD, EPC<=(M_BD ? M_PC-8 : M_PC-4) with bits[1:0] forced 0 (consumer resumes at EPC_out+4).
REQ-020 Cause.IP <= hw_int every cycle regardless of state.
REQ-021 mtc0 writes SR (IM, EXL, IE only) or EPC (bits[1:0] forced 0); Cause and unmapped addresses are read-only/ignored.
REQ-022 Req and we in the same cycle: Req update wins, mtc0 discarded.
REQ-023 M_eret and mtc0 to SR in the same cycle: IM/IE take wdata, EXL forced 0.
REQ-024 M_eret with EXL=0: no state change.
REQ-025 rdata returns pre-edge register value; no write-to-read bypass in the same cycle.
REQ-026 Req is never asserted while EXL=1 (no nested exceptions).

Reset
REQ-027 On reset high, immediately: SR=0, Cause=0, EPC=0, EBase=32'h0000_4180; Req=0, rdata from reset values.
REQ-028 Reset asserted mid-handler returns to NORMAL; pending hw_int not latched until reset released.

Configuration
REQ-029 Macro CP0_EBASE_WR_EN: when defined, register 15 is EBase, writable by mtc0 with bits[11:0] forced 0 and readable via mfc0.
REQ-030 Without CP0_EBASE_WR_EN: EBase_out is constant 32'h0000_4180, register 15 reads 0, writes ignored.

Structure
REQ-031 Shared package cp0_pkg holds register numbers (SR=12, CAUSE=13, EPC=14, EBASE=15), ExcCode constants (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12), EBASE_RESET.
REQ-032 One sub-module cp0_req_arb computes int_pend, Req and the latched ExcCode; register file stays in cp0_ctrl.

Verification
REQ-033 SR=0x0000_0401, hw_int=6'b000001, EXL=0 -> Req=1 same cycle; next edge EXL=1, ExcCode=0, EPC=M_PC-4.
REQ-034 exc_code=8, M_PC=0x3010, M_BD=1 -> Req=1; after edge EPC=0x3008, BD=1, ExcCode=8.
REQ-035 EXL=1, exc_code=4 -> Req=0, no register change; then M_eret -> EXL=0 next edge.
REQ-036 we=1 addr=14 wdata=0x3333 simultaneous with exc_code=12 -> EPC holds exception value, not 0x3330.
REQ-037 Reset pulsed while EXL=1 -> SR/Cause/EPC read 0, EBase_out=0x4180 without waiting for clk.
REQ-038 With CP0_EBASE_WR_EN, mtc0 addr=15 wdata=0x8000_0FFF -> EBase_out=0x8000_0000; without the macro EBase_out stays 0x4180.
